// File: rtl/shift_pkg.sv
// shift_pkg: shared encodings and entry type for the execute-stage shift unit.
// Holds op-kind codes, the variable-distance bit index and shift_entry_t.
package shift_pkg;

  localparam int SH_WIDTH = 32;
  localparam int SH_TAGW  = 5;

  localparam logic [1:0] SH_LL = 2'b00;
  localparam logic [1:0] SH_RL = 2'b10;
  localparam logic [1:0] SH_RA = 2'b11;
  localparam int         SH_VAR = 2;

  typedef struct packed {
    logic [SH_WIDTH-1:0] result;
    logic [SH_TAGW-1:0]  tag;
  } shift_entry_t;

endpackage

// File: rtl/shift_core.sv
// shift_core: combinational 5-level mux barrel shifter.
// Ports: i_data (value), i_dist (0..31), i_kind (op[1:0]), o_result.
module shift_core
  import shift_pkg::*;
(
  input  logic [SH_WIDTH-1:0] i_data,
  input  logic [4:0]          i_dist,
  input  logic [1:0]          i_kind,
  output logic [SH_WIDTH-1:0] o_result
);

  logic                w_left;
  logic                w_right;
  logic                w_fill;
  logic [SH_WIDTH-1:0] w_v;

  assign w_left  = (i_kind == SH_LL);
  assign w_right = (i_kind == SH_RL) || (i_kind == SH_RA);
  assign w_fill  = (i_kind == SH_RA) && i_data[SH_WIDTH-1];

  // Level i shifts by 2**i when dist bit i is set; reserved kind passes.
  always_comb begin
    w_v = i_data;
    for (int i = 0; i < 5; i++) begin
      if (i_dist[i]) begin
        unique case (1'b1)
          w_left:  w_v = w_v << (1 << i);
          w_right: w_v = (w_v >> (1 << i))
                       | (w_fill ? ~({SH_WIDTH{1'b1}} >> (1 << i))
                                 : {SH_WIDTH{1'b0}});
          default: w_v = w_v;
        endcase
      end
    end
  end

  assign o_result = w_v;

endmodule

// File: rtl/shift_stage.sv
// shift_stage: execute-stage MIPS shift unit, 1-cycle valid/ready stage.
// Ports: clock, rst (async high); in_valid/in_ready, in_op, in_shamt,
// in_rs, in_rt, in_tag; out_valid/out_ready, out_result, out_tag.
// Build option SHIFT_SKID_EN adds a skid entry and a registered in_ready.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [4:0]       in_shamt,
  input  logic [WIDTH-1:0] in_rs,
  input  logic [WIDTH-1:0] in_rt,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAGW-1:0]  out_tag
);

  logic [4:0]       w_dist;
  logic [WIDTH-1:0] w_res;
  shift_entry_t     w_new;
  logic             w_acc;
  logic             w_take;
  logic             w_unused_rs;

  shift_entry_t     r_out;
  logic             r_out_valid;

  assign w_unused_rs = ^in_rs[WIDTH-1:5];

  assign w_dist = in_op[SH_VAR] ? in_rs[4:0] : in_shamt;

  shift_core u_core (
    .i_data   (in_rt),
    .i_dist   (w_dist),
    .i_kind   (in_op[1:0]),
    .o_result (w_res)
  );

  assign w_new.result = w_res;
  assign w_new.tag    = in_tag;

  assign w_acc  = in_valid && in_ready;
  assign w_take = r_out_valid && out_ready;

  assign out_valid  = r_out_valid;
  assign out_result = r_out.result;
  assign out_tag    = r_out.tag;

`ifdef SHIFT_SKID_EN

  shift_entry_t r_skid;
  logic         r_skid_valid;
  logic         r_in_ready;

  assign in_ready = r_in_ready;

  // r_in_ready always tracks !r_skid_valid, kept as its own flop so
  // upstream never sees a path from out_ready.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      if (!r_out_valid || w_take) begin
        if (r_skid_valid) begin
          r_out        <= r_skid;
          r_out_valid  <= 1'b1;
          r_skid_valid <= 1'b0;
          r_in_ready   <= 1'b1;
        end else if (w_acc) begin
          r_out       <= w_new;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_acc) begin
        r_skid       <= w_new;
        r_skid_valid <= 1'b1;
        r_in_ready   <= 1'b0;
      end
    end
  end

`else

  assign in_ready = !r_out_valid || out_ready;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_acc) begin
      r_out       <= w_new;
      r_out_valid <= 1'b1;
    end else if (w_take) begin
      r_out_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_shift_stage.sv
// tb_shift_stage: directed + random bench for shift_stage.
// Reference model is plain shift arithmetic with a FIFO scoreboard.
module tb_shift_stage;

  logic        clock = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_shamt;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;

  always #5 clock = ~clock;

  shift_stage #(.WIDTH(32), .TAGW(5)) dut (
    .clock      (clock),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_shamt   (in_shamt),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

`ifdef SHIFT_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   taken = 0;
  logic acc;

  function automatic logic [31:0] model(input logic [2:0] op,
                                        input logic [4:0] sh,
                                        input logic [31:0] rs,
                                        input logic [31:0] rt);
    int d;
    d = op[2] ? int'(rs[4:0]) : int'(sh);
    case (op[1:0])
      2'b00:   return rt << d;
      2'b10:   return rt >> d;
      2'b11:   return $signed(rt) >>> d;
      default: return rt;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [2:0] op, input logic [4:0] sh,
                     input logic [31:0] rs, input logic [31:0] rt,
                     input logic [4:0] tg);
    in_valid = 1'b1;
    in_op    = op;
    in_shamt = sh;
    in_rs    = rs;
    in_rt    = rt;
    in_tag   = tg;
  endtask

  task automatic put_rand();
    put(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
        $urandom, $urandom, 5'($urandom_range(0, 31)));
  endtask

  // One clock: check outputs against the scoreboard, then advance it
  // with whatever handshakes complete at the coming edge.
  task automatic cycle();
    logic exp_rdy;
    logic exp_vld;
    #1;
    exp_vld = (q.size() != 0);
    exp_rdy = SKID ? (q.size() < 2) : (!exp_vld || out_ready);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_vld));
    if (out_valid && exp_vld) begin
      chk("out_result", out_result, q[0].res);
      chk("out_tag", 32'(out_tag), 32'(q[0].tag));
    end
    acc = in_valid && in_ready;
    if (out_valid && out_ready && exp_vld) begin
      void'(q.pop_front());
      taken++;
    end
    if (acc)
      q.push_back(exp_t'{model(in_op, in_shamt, in_rs, in_rt), in_tag});
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] rt;
    int n;
    int cyc;
    int t0;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_shamt  = '0;
    in_rs     = '0;
    in_rt     = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clock);
    #1;

    put(3'b000, 5'd4, 32'h0, 32'h0000_0030, 5'd9);
    cycle();
    chk("sll_result", out_result, 32'h0000_0300);
    chk("sll_tag", 32'(out_tag), 32'd9);
    put(3'b111, 5'd0, 32'hFFFF_FFE1, 32'h8000_0000, 5'd2);
    cycle();
    chk("srav_result", out_result, 32'hC000_0000);
    put(3'b110, 5'd0, 32'hFFFF_FFE1, 32'h8000_0000, 5'd0);
    cycle();
    chk("srlv_result", out_result, 32'h4000_0000);
    chk("tag0", 32'(out_tag), 32'd0);
    put(3'b001, 5'd7, 32'h0, 32'hDEAD_BEEF, 5'd4);
    cycle();
    chk("rsvd_result", out_result, 32'hDEAD_BEEF);
    for (int op = 0; op < 8; op++) begin
      rt = $urandom | 32'h8000_0001;
      put(3'(op), 5'd0, $urandom & 32'hFFFF_FFE0, rt, 5'(op));
      cycle();
      chk("dist0_result", out_result, rt);
    end
    in_valid = 1'b0;
    cycle();
    cycle();

    n   = 0;
    cyc = 0;
    t0  = taken;
    while ((n < 4 || q.size() != 0) && cyc < 40) begin
      if (n < 4) put(3'b000, 5'(n + 1), 32'h0, $urandom, 5'(n + 20));
      else in_valid = 1'b0;
      out_ready = (cyc == 0) || (cyc > 3);
      cycle();
      if (acc) n++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_accepted", 32'(n), 32'd4);
    chk("stream_taken", 32'(taken - t0), 32'd4);

    out_ready = 1'b0;
    put(3'b011, 5'd4, 32'h0, 32'hF000_0000, 5'd17);
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", out_result, 32'd0);
    chk("midrst_tag", 32'(out_tag), 32'd0);
    q.delete();
    @(posedge clock);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    put(3'b000, 5'd1, 32'h0, 32'h0000_0001, 5'd3);
    cycle();
    in_valid = 1'b0;
    chk("postrst_result", out_result, 32'h0000_0002);
    chk("postrst_tag", 32'(out_tag), 32'd3);
    cycle();

    out_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      put_rand();
      cycle();
    end
    for (int i = 0; i < 3000; i++) begin
      put_rand();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && q.size() != 0; i++) cycle();
    chk("drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
